// File: rtl/fractal_ctrl_pkg.sv
// fractal_ctrl_pkg: register map, control bits and shared types for the fractal parameter sequencer
package fractal_ctrl_pkg;

    localparam logic [3:0] REG_CTRL      = 4'd0;
    localparam logic [3:0] REG_CR_BASE   = 4'd1;
    localparam logic [3:0] REG_CI_BASE   = 4'd2;
    localparam logic [3:0] REG_DCR       = 4'd3;
    localparam logic [3:0] REG_DCI       = 4'd4;
    localparam logic [3:0] REG_DX        = 4'd5;
    localparam logic [3:0] REG_DY        = 4'd6;
    localparam logic [3:0] REG_X0        = 4'd7;
    localparam logic [3:0] REG_Y0        = 4'd8;
    localparam logic [3:0] REG_NSTEPS    = 4'd9;
    localparam logic [3:0] REG_FRAME_DIV = 4'd10;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_STEP   = 1;
    localparam int CTRL_COMMIT = 2;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} seq_state_t;
    typedef enum logic {FWD = 1'b0, BWD = 1'b1} path_dir_t;

endpackage

// File: rtl/fractal_c_stepper.sv
// fractal_c_stepper: walks the Julia constant back and forth along base + idx*delta, idx in [0, nsteps]
module fractal_c_stepper
    import fractal_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               advance,
    input  logic               load,
    input  logic signed [31:0] base_cr,
    input  logic signed [31:0] base_ci,
    input  logic signed [31:0] delta_cr,
    input  logic signed [31:0] delta_ci,
    input  logic [31:0]        nsteps,
    output logic signed [31:0] cr,
    output logic signed [31:0] ci
);

    logic [31:0] idx;
    path_dir_t   dir;
    logic        at_end, up;

    // >= keeps the walk bounded if nsteps is lowered below idx mid-path
    always_comb begin
        at_end = (dir == FWD) ? (idx >= nsteps) : (idx == '0);
        up     = (dir == FWD) ^ at_end;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cr  <= '0;
            ci  <= '0;
            idx <= '0;
            dir <= FWD;
        end else if (load) begin
            cr  <= base_cr;
            ci  <= base_ci;
            idx <= '0;
            dir <= FWD;
        end else if (advance && nsteps != '0) begin
            idx <= up ? idx + 32'd1 : idx - 32'd1;
            cr  <= up ? cr + delta_cr : cr - delta_cr;
            ci  <= up ? ci + delta_ci : ci - delta_ci;
            dir <= at_end ? ((dir == FWD) ? BWD : FWD) : dir;
        end
    end

endmodule

// File: rtl/fractal_param_sequencer.sv
// fractal_param_sequencer: host shadow registers committed at frame boundaries, plus Julia-constant animation
module fractal_param_sequencer
    import fractal_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               reg_wr,
    input  logic [3:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    input  logic               frame_start_in,
    input  logic               data_enable_in,
    output logic signed [31:0] cr_out,
    output logic signed [31:0] ci_out,
    output logic signed [31:0] dx_out,
    output logic signed [31:0] dy_out,
    output logic signed [31:0] x0_out,
    output logic signed [31:0] y0_out,
    output logic [CNT_W-1:0]   frame_count,
    output logic               running
);

    logic [31:0]      shd [REG_CR_BASE:REG_FRAME_DIV];
    seq_state_t       state, state_n;
    logic             pending, pending_n, armed, armed_n;
    logic [CNT_W-1:0] div_cnt;
    logic             b, ctrl_wr, shd_sel, apply, div_hit, advance;
    logic [31:0]      div_eff;

    assign b       = frame_start_in && data_enable_in;
    assign ctrl_wr = reg_wr && reg_addr == REG_CTRL;
    assign shd_sel = reg_addr >= REG_CR_BASE && reg_addr <= REG_FRAME_DIV;
    assign apply   = b && pending;
    assign div_eff = (shd[REG_FRAME_DIV] == '0) ? 32'd1 : shd[REG_FRAME_DIV];
    assign div_hit = div_cnt == CNT_W'(div_eff - 32'd1);
    assign running = state == RUN;

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_n;
    end

    // A pending commit at B wins over any advance; a step only arms while already paused
    always_comb begin
        state_n   = state;
        pending_n = pending;
        armed_n   = armed;
        advance   = 1'b0;
        if (ctrl_wr)
            state_n = reg_wdata[CTRL_RUN] ? RUN : ((state == IDLE) ? IDLE : PAUSED);
        pending_n = (ctrl_wr && reg_wdata[CTRL_COMMIT]) ? 1'b1 : (apply ? 1'b0 : pending);
        armed_n   = (state_n != PAUSED) ? 1'b0 :
                    (ctrl_wr && reg_wdata[CTRL_STEP] && state == PAUSED) ? 1'b1 :
                    b ? 1'b0 : armed;
        advance   = b && !pending && ((state == RUN) ? div_hit : (state == PAUSED && armed));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending     <= 1'b0;
            armed       <= 1'b0;
            div_cnt     <= '0;
            frame_count <= '0;
            dx_out      <= '0;
            dy_out      <= '0;
            x0_out      <= '0;
            y0_out      <= '0;
            reg_rdata   <= '0;
            for (int i = 1; i <= 10; i++)
                shd[i] <= '0;
        end else begin
            pending <= pending_n;
            armed   <= armed_n;
            if (reg_wr && shd_sel)
                shd[reg_addr] <= reg_wdata;
            if (b)
                frame_count <= frame_count + CNT_W'(1);
            if (apply) begin
                div_cnt <= '0;
                dx_out  <= shd[REG_DX];
                dy_out  <= shd[REG_DY];
                x0_out  <= shd[REG_X0];
                y0_out  <= shd[REG_Y0];
            end else if (b && state == RUN) begin
                div_cnt <= div_hit ? '0 : div_cnt + CNT_W'(1);
            end
            reg_rdata <= (reg_addr == REG_CTRL) ? {27'd0, state, pending, 2'b00} :
                         shd_sel ? shd[reg_addr] : 32'd0;
        end
    end

    fractal_c_stepper u_stepper (
        .clk      (clk),
        .resetn   (resetn),
        .advance  (advance),
        .load     (apply),
        .base_cr  (shd[REG_CR_BASE]),
        .base_ci  (shd[REG_CI_BASE]),
        .delta_cr (shd[REG_DCR]),
        .delta_ci (shd[REG_DCI]),
        .nsteps   (shd[REG_NSTEPS]),
        .cr       (cr_out),
        .ci       (ci_out)
    );

endmodule

// File: tb/tb_fractal_param_sequencer.sv
// tb_fractal_param_sequencer: scoreboard bench; expected c follows base + triangle(advances)*delta
module tb_fractal_param_sequencer;
    import fractal_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               reg_wr = 1'b0;
    logic [3:0]         reg_addr = '0;
    logic [31:0]        reg_wdata = '0;
    logic [31:0]        reg_rdata;
    logic               frame_start_in = 1'b0;
    logic               data_enable_in = 1'b0;
    logic signed [31:0] cr_out, ci_out, dx_out, dy_out, x0_out, y0_out;
    logic [31:0]        frame_count;
    logic               running;

    fractal_param_sequencer #(.CNT_W(32)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .reg_wr         (reg_wr),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_rdata      (reg_rdata),
        .frame_start_in (frame_start_in),
        .data_enable_in (data_enable_in),
        .cr_out         (cr_out),
        .ci_out         (ci_out),
        .dx_out         (dx_out),
        .dy_out         (dy_out),
        .x0_out         (x0_out),
        .y0_out         (y0_out),
        .frame_count    (frame_count),
        .running        (running)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cr;
        logic [31:0] ci;
        logic [31:0] fc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] sh [0:15];
    logic [31:0] m_base_cr, m_base_ci, m_fc;
    int unsigned m_p;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] path_idx(input int unsigned p, input logic [31:0] n);
        int unsigned m;
        if (n == 0) return 32'd0;
        m = p % (2 * n);
        return (m <= n) ? m : 2 * n - m;
    endfunction

    function automatic exp_t model_now();
        exp_t e;
        e.cr = m_base_cr + path_idx(m_p, sh[REG_NSTEPS]) * sh[REG_DCR];
        e.ci = m_base_ci + path_idx(m_p, sh[REG_NSTEPS]) * sh[REG_DCI];
        e.fc = m_fc;
        return e;
    endfunction

    // kind: 0 = B leaves c alone, 1 = B advances the path, 2 = B applies a pending commit
    task automatic cyc(input logic wr, input logic [3:0] a, input logic [31:0] d,
                       input int kind, input logic fs, input logic de);
        exp_t e;
        reg_wr = wr; reg_addr = a; reg_wdata = d;
        frame_start_in = fs; data_enable_in = de;
        if (fs && de) begin
            m_fc++;
            if (kind == 1) m_p++;
            if (kind == 2) begin
                m_p = 0;
                m_base_cr = sh[REG_CR_BASE];
                m_base_ci = sh[REG_CI_BASE];
            end
        end
        if (fs || de) sb.push_back(model_now());
        @(posedge clk); #1;
        reg_wr = 1'b0; frame_start_in = 1'b0; data_enable_in = 1'b0;
        if (wr && a >= REG_CR_BASE && a <= REG_FRAME_DIV) sh[a] = d;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("cr_out", cr_out, e.cr);
            check("ci_out", ci_out, e.ci);
            check("frame_count", frame_count, e.fc);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(1'b1, a, d, 0, 1'b0, 1'b0);
    endtask

    task automatic frame(input int kind);
        cyc(1'b0, 4'd0, 32'd0, kind, 1'b1, 1'b1);
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] want);
        reg_addr = a;
        @(posedge clk); #1;
        check(tag, reg_rdata, want);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) sh[i] = '0;
        m_base_cr = '0; m_base_ci = '0; m_fc = '0; m_p = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_cr"}, cr_out, 32'd0);
        check({tag, "_ci"}, ci_out, 32'd0);
        check({tag, "_dx"}, dx_out, 32'd0);
        check({tag, "_dy"}, dy_out, 32'd0);
        check({tag, "_x0"}, x0_out, 32'd0);
        check({tag, "_y0"}, y0_out, 32'd0);
        check({tag, "_fc"}, frame_count, 32'd0);
        check({tag, "_running"}, {31'd0, running}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        check_zero_outputs("reset");
        check("reset_rdata", reg_rdata, 32'd0);

        wr(REG_CR_BASE, 32'h1000);
        wr(REG_CI_BASE, 32'h200);
        wr(REG_DX, 32'd5);
        wr(REG_DY, 32'd6);
        wr(REG_X0, 32'hFFFF_FFF9);
        wr(REG_Y0, 32'd8);
        rd("rd_dx", REG_DX, 32'd5);
        rd("rd_x0", REG_X0, 32'hFFFF_FFF9);
        wr(REG_CTRL, 32'd4);
        rd("rd_ctrl_pending", REG_CTRL, 32'h4);
        check("cr_before_b", cr_out, 32'd0);
        frame(2);
        check("dx_after_commit", dx_out, 32'd5);
        check("dy_after_commit", dy_out, 32'd6);
        check("x0_after_commit", x0_out, 32'hFFFF_FFF9);
        check("y0_after_commit", y0_out, 32'd8);
        rd("rd_ctrl_idle", REG_CTRL, 32'h0);

        wr(REG_NSTEPS, 32'd2);
        wr(REG_DCR, 32'h10);
        wr(REG_DCI, 32'd1);
        wr(REG_FRAME_DIV, 32'd1);
        frame(0);
        wr(REG_CTRL, 32'd1);
        check("running_run", {31'd0, running}, 32'd1);
        rd("rd_ctrl_run", REG_CTRL, 32'h8);
        repeat (5) frame(1);
        check("cr_path_end", cr_out, 32'h1010);

        wr(REG_FRAME_DIV, 32'd3);
        frame(0); frame(0); frame(1);
        frame(0); frame(0); frame(1);

        wr(REG_CTRL, 32'd0);
        rd("rd_ctrl_paused", REG_CTRL, 32'h10);
        frame(0);
        wr(REG_CTRL, 32'd2);
        frame(1);
        frame(0);

        wr(REG_CR_BASE, 32'h3000);
        cyc(1'b1, REG_CTRL, 32'd4, 0, 1'b1, 1'b1);
        rd("rd_ctrl_paused_pending", REG_CTRL, 32'h14);
        wr(REG_CTRL, 32'd2);
        cyc(1'b1, REG_CR_BASE, 32'h5000, 2, 1'b1, 1'b1);
        rd("rd_cr_base_new", REG_CR_BASE, 32'h5000);
        rd("rd_ctrl_after_apply", REG_CTRL, 32'h10);

        wr(REG_FRAME_DIV, 32'd0);
        rd("rd_frame_div", REG_FRAME_DIV, 32'd0);
        wr(REG_CTRL, 32'd1);
        frame(1);
        frame(1);
        cyc(1'b0, 4'd0, 32'd0, 0, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 0, 1'b0, 1'b1);
        wr(REG_CTRL, 32'd5);
        frame(2);
        frame(1);

        wr(4'd12, 32'hDEAD_BEEF);
        rd("rd_unmapped_12", 4'd12, 32'd0);
        rd("rd_unmapped_15", 4'd15, 32'd0);

        wr(REG_CTRL, 32'd5);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        model_reset();
        check_zero_outputs("midreset");
        rd("rd_ctrl_midreset", REG_CTRL, 32'h0);
        rd("rd_cr_base_midreset", REG_CR_BASE, 32'h0);
        frame(0);
        check("dx_after_reset_b", dx_out, 32'd0);
        check("running_after_reset_b", {31'd0, running}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
